// File: rtl/alu_issue_ctrl_pkg.sv
// Shared decode constants, FSM state encoding and instruction field layout
// for the ALU issue/writeback controller.
package alu_pkg;

  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_MUL  = 4'b0100;
  localparam logic [3:0] FN_DIV  = 4'b0101;
  localparam logic [3:0] FN_MOV  = 4'b0111;
  localparam logic [3:0] FN_SWAP = 4'b1000;

  localparam int FUNCT_LSB = 12;
  localparam int RD_LSB    = 8;
  localparam int RS_LSB    = 4;
  localparam int RT_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_WB2
  } state_e;

  function automatic logic fn_legal(input logic [3:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_MUL) ||
           (f == FN_DIV) || (f == FN_MOV) || (f == FN_SWAP);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction valid/ready handshake between the instruction producer (master)
// and the issue controller (slave).
interface alu_issue_ctrl_if #(parameter int W = 16);
  logic [W-1:0] instr;
  logic         instr_valid;
  logic         instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// 16-entry register file: two operand ports latched on re, a combinational
// peek port (old R[rd] for SWAP), a combinational debug port, one write port.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREG = 16,
  parameter int W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    re,
  input  logic [$clog2(NREG)-1:0] ra_a,
  input  logic [$clog2(NREG)-1:0] ra_b,
  output logic [W-1:0]            rdata_a_q,
  output logic [W-1:0]            rdata_b_q,
  input  logic [$clog2(NREG)-1:0] ra_c,
  output logic [W-1:0]            rdata_c,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic [W-1:0]            wd,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [W-1:0]            dbg_data
);

  logic [W-1:0] mem_q [NREG];

  // R0 reads as zero regardless of storage contents
  function automatic logic [W-1:0] rd_reg(input logic [$clog2(NREG)-1:0] a);
    return (a == '0) ? '0 : mem_q[a];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem_q[wa] <= wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else if (re) begin
      rdata_a_q <= rd_reg(ra_a);
      rdata_b_q <= rd_reg(ra_b);
    end
  end

  assign rdata_c  = rd_reg(ra_c);
  assign dbg_data = rd_reg(dbg_addr);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of a combinational ALU: decodes register
// instructions, feeds operands, writes results back and adds ovf/dz/illegal flags.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NREG = 16,
  parameter int W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_ctrl_if.slave     ibus,
  output logic [3:0]          functCode,
  output logic signed [W-1:0] op1,
  output logic signed [W-1:0] op2,
  input  logic [W-1:0]        alu_result,
  input  logic [W-1:0]        alu_remainder,
  output logic                done,
  output logic                ovf,
  output logic                dz,
  output logic                illegal,
  output logic [W-1:0]        rem_q,
  input  logic [3:0]          dbg_addr,
  output logic [W-1:0]        dbg_data
);

  state_e       state_q, state_d;
  logic [W-1:0] instr_q;
  logic [3:0]   fn_q;
  logic [W-1:0] old_rd_q, res_q, rem_cand_q;
  logic         ovf_p_q, dz_p_q, ill_p_q;
  logic         done_q, ovf_q, dz_q, ill_q;
  logic [W-1:0] rdata_a, rdata_b, rdata_c;
  logic         re, we, retire, accept;
  logic [3:0]   wa;
  logic [W-1:0] wd;
  logic [3:0]   rd_f, rs_f, rt_f;

  function automatic logic add_sub_ovf(input logic [3:0] f, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [W-1:0] r);
    logic sa, sb, sr;
    sa = a[W-1];
    sb = b[W-1];
    sr = r[W-1];
    if (f == FN_ADD) return (sa == sb) && (sr != sa);
    if (f == FN_SUB) return (sa != sb) && (sr != sa);
    return 1'b0;
  endfunction

  assign rd_f = instr_q[RD_LSB +: 4];
  assign rs_f = instr_q[RS_LSB +: 4];
  assign rt_f = instr_q[RT_LSB +: 4];

  assign ibus.instr_ready = (state_q == ST_IDLE);
  assign accept           = ibus.instr_valid && (state_q == ST_IDLE);

  alu_regfile #(.NREG(NREG), .W(W)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .re        (re),
    .ra_a      (rs_f),
    .ra_b      (rt_f),
    .rdata_a_q (rdata_a),
    .rdata_b_q (rdata_b),
    .ra_c      (rd_f),
    .rdata_c   (rdata_c),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always_comb begin
    state_d = state_q;
    re      = 1'b0;
    we      = 1'b0;
    wa      = rd_f;
    wd      = res_q;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_READ;
      ST_READ: begin
        re      = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        case (fn_q)
          FN_ADD, FN_SUB, FN_MUL, FN_MOV: we = 1'b1;
          FN_DIV:  we = !dz_p_q;
          FN_SWAP: begin
            we = 1'b1;
            wd = rdata_a;
          end
          default: we = 1'b0;
        endcase
        if (fn_q == FN_SWAP) begin
          state_d = ST_WB2;
        end else begin
          state_d = ST_IDLE;
          retire  = 1'b1;
        end
      end
      ST_WB2: begin
        we      = 1'b1;
        wa      = rs_f;
        wd      = old_rd_q;
        retire  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and architecturally visible state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fn_q    <= '0;
      ovf_p_q <= 1'b0;
      dz_p_q  <= 1'b0;
      ill_p_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= retire;
      if (state_q == ST_READ) fn_q <= instr_q[FUNCT_LSB +: 4];
      if (state_q == ST_EXEC) begin
        ovf_p_q <= add_sub_ovf(fn_q, rdata_a, rdata_b, alu_result);
        dz_p_q  <= (fn_q == FN_DIV) && (rdata_b == '0);
        ill_p_q <= !fn_legal(fn_q);
      end
      if (retire) begin
        ovf_q <= ovf_p_q;
        dz_q  <= dz_p_q;
        ill_q <= ill_p_q;
      end
      if ((state_q == ST_WB) && (fn_q == FN_DIV) && !dz_p_q) rem_q <= rem_cand_q;
    end
  end

  // Datapath latches; values are only consumed after being loaded
  always_ff @(posedge clk) begin
    if (accept) instr_q <= ibus.instr;
    if (state_q == ST_READ) old_rd_q <= rdata_c;
    if (state_q == ST_EXEC) begin
      res_q      <= alu_result;
      rem_cand_q <= alu_remainder;
    end
  end

  assign functCode = fn_q;
  assign op1       = rdata_a;
  assign op2       = rdata_b;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a flag/latency
// scoreboard filled at issue time and drained at retirement.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  typedef struct {
    logic o;
    logic d;
    logic i;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.W(16)) ibus ();

  logic [3:0]          functCode;
  logic signed [15:0]  op1, op2;
  logic [15:0]         alu_result, alu_remainder, rem_q, dbg_data;
  logic                done, ovf, dz, illegal;
  logic [3:0]          dbg_addr;
  logic                inj_en;
  logic [15:0]         inj_val;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  alu_issue_ctrl #(.NREG(16), .W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .ibus          (ibus),
    .functCode     (functCode),
    .op1           (op1),
    .op2           (op2),
    .alu_result    (alu_result),
    .alu_remainder (alu_remainder),
    .done          (done),
    .ovf           (ovf),
    .dz            (dz),
    .illegal       (illegal),
    .rem_q         (rem_q),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  // Behavioural ALU; MOV can inject a constant so registers can be preloaded
  always_comb begin
    alu_result    = '0;
    alu_remainder = '0;
    case (functCode)
      FN_ADD: alu_result = op1 + op2;
      FN_SUB: alu_result = op1 - op2;
      FN_MUL: alu_result = op1 * op2;
      FN_DIV: if (op2 != 0) begin
        alu_result    = op1 / op2;
        alu_remainder = op1 % op2;
      end
      FN_MOV: alu_result = inj_en ? inj_val : op1;
      default: ;
    endcase
  end

  function automatic logic [15:0] mk(input logic [3:0] f, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [3:0] rt);
    return {f, rd, rs, rt};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic issue(input string tag, input logic [15:0] ins,
                       input logic eo, input logic ed, input logic ei, input int lat);
    exp_t e;
    int   n;
    sb.push_back('{o: eo, d: ed, i: ei, lat: lat});
    @(negedge clk);
    ibus.instr       = ins;
    ibus.instr_valid = 1'b1;
    n = 0;
    while (!ibus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 ibus.instr_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 20);
    e = sb.pop_front();
    chk({tag, "_done"},    {15'd0, done},    16'd1);
    chk({tag, "_latency"}, 16'(n),           16'(e.lat));
    chk({tag, "_ovf"},     {15'd0, ovf},     {15'd0, e.o});
    chk({tag, "_dz"},      {15'd0, dz},      {15'd0, e.d});
    chk({tag, "_illegal"}, {15'd0, illegal}, {15'd0, e.i});
  endtask

  task automatic load(input logic [3:0] rd, input logic [15:0] v);
    inj_val = v;
    inj_en  = 1'b1;
    issue("load", mk(FN_MOV, rd, 4'd0, 4'd0), 1'b0, 1'b0, 1'b0, 3);
    inj_en  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst              = 1'b1;
    ibus.instr       = '0;
    ibus.instr_valid = 1'b0;
    inj_en           = 1'b0;
    inj_val          = '0;
    dbg_addr         = '0;
    #23;
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_ready",     {15'd0, ibus.instr_ready}, 16'd1);
    chk("rst_done",      {15'd0, done},    16'd0);
    chk("rst_flags",     {13'd0, ovf, dz, illegal}, 16'd0);
    chk("rst_functCode", {12'd0, functCode}, 16'd0);
    chk("rst_op1",       op1,   16'd0);
    chk("rst_op2",       op2,   16'd0);
    chk("rst_rem",       rem_q, 16'd0);
    chk_reg("rst_r5", 4'd5, 16'd0);

    // signed ADD overflow
    load(4'd1, 16'h7FFF);
    load(4'd2, 16'h0001);
    chk_reg("load_r1", 4'd1, 16'h7FFF);
    issue("add_ovf", mk(FN_ADD, 4'd3, 4'd1, 4'd2), 1'b1, 1'b0, 1'b0, 3);
    chk_reg("add_r3", 4'd3, 16'h8000);

    // DIV, then DIV by zero leaves rd and rem_q alone
    load(4'd1, 16'h0011);
    load(4'd2, 16'h0005);
    issue("div", mk(FN_DIV, 4'd4, 4'd1, 4'd2), 1'b0, 1'b0, 1'b0, 3);
    chk_reg("div_r4", 4'd4, 16'h0003);
    chk("div_rem", rem_q, 16'h0002);
    load(4'd5, 16'hBEEF);
    issue("div0", mk(FN_DIV, 4'd5, 4'd1, 4'd0), 1'b0, 1'b1, 1'b0, 3);
    chk_reg("div0_r5", 4'd5, 16'hBEEF);
    chk("div0_rem", rem_q, 16'h0002);

    // SUB overflow, then MUL/SUB clearing it
    load(4'd1, 16'h8000);
    load(4'd2, 16'h0001);
    issue("sub_ovf", mk(FN_SUB, 4'd8, 4'd1, 4'd2), 1'b1, 1'b0, 1'b0, 3);
    chk_reg("sub_r8", 4'd8, 16'h7FFF);
    load(4'd1, 16'hFFFD);
    load(4'd2, 16'h0004);
    issue("mul", mk(FN_MUL, 4'd6, 4'd1, 4'd2), 1'b0, 1'b0, 1'b0, 3);
    chk_reg("mul_r6", 4'd6, 16'hFFF4);
    issue("sub_neg", mk(FN_SUB, 4'd7, 4'd0, 4'd1), 1'b0, 1'b0, 1'b0, 3);
    chk_reg("sub_r7", 4'd7, 16'h0003);

    // SWAP takes one extra cycle; writes to R0 are dropped
    load(4'd1, 16'h1234);
    load(4'd2, 16'hABCD);
    issue("swap", mk(FN_SWAP, 4'd1, 4'd2, 4'd0), 1'b0, 1'b0, 1'b0, 4);
    chk_reg("swap_r1", 4'd1, 16'hABCD);
    chk_reg("swap_r2", 4'd2, 16'h1234);
    issue("add_r0", mk(FN_ADD, 4'd0, 4'd1, 4'd2), 1'b0, 1'b0, 1'b0, 3);
    chk_reg("r0_zero", 4'd0, 16'h0000);

    // illegal funct: no writes
    issue("illegal", mk(4'b0010, 4'd1, 4'd2, 4'd2), 1'b0, 1'b0, 1'b1, 3);
    chk_reg("ill_r1", 4'd1, 16'hABCD);
    chk_reg("ill_r2", 4'd2, 16'h1234);

    // instr_valid held across a busy instruction
    @(negedge clk);
    ibus.instr       = mk(FN_ADD, 4'd9, 4'd1, 4'd2);
    ibus.instr_valid = 1'b1;
    @(posedge clk);
    #1 ibus.instr = mk(FN_SUB, 4'd10, 4'd1, 4'd2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ibus.instr_ready && n < 20);
    chk("busy_ready_gap", 16'(n), 16'd4);
    chk("busy_idle_done", {15'd0, done}, 16'd1);
    chk_reg("busy_r9", 4'd9, 16'hBE01);
    chk_reg("busy_r10_pre", 4'd10, 16'h0000);
    @(posedge clk);
    #1 ibus.instr_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 20);
    chk("busy_b_latency", 16'(n), 16'd3);
    chk_reg("busy_r10", 4'd10, 16'h9999);

    // reset during WB of ADD R3
    load(4'd1, 16'h0001);
    load(4'd2, 16'h0002);
    issue("div0b", mk(FN_DIV, 4'd11, 4'd1, 4'd0), 1'b0, 1'b1, 1'b0, 3);
    @(negedge clk);
    ibus.instr       = mk(FN_ADD, 4'd3, 4'd1, 4'd2);
    ibus.instr_valid = 1'b1;
    @(posedge clk);
    #1 ibus.instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("wbrst_ready", {15'd0, ibus.instr_ready}, 16'd1);
    chk("wbrst_flags", {12'd0, done, ovf, dz, illegal}, 16'd0);
    chk("wbrst_functCode", {12'd0, functCode}, 16'd0);
    chk("wbrst_op1", op1, 16'd0);
    chk("wbrst_op2", op2, 16'd0);
    chk("wbrst_rem", rem_q, 16'd0);
    @(negedge clk) rst = 1'b0;
    chk_reg("wbrst_r3", 4'd3, 16'h0000);
    chk_reg("wbrst_r2", 4'd2, 16'h0000);
    repeat (4) @(posedge clk);
    #1;
    chk("wbrst_no_done", {15'd0, done}, 16'd0);
    chk("wbrst_ready_after", {15'd0, ibus.instr_ready}, 16'd1);
    chk_reg("wbrst_r3_late", 4'd3, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Instruction-issue and writeback controller sitting in front of the combinational ALU. It accepts 16-bit register-format instructions over a valid/ready handshake and decodes the function code. It reads operands from an internal 16×16 register file, drives the ALU's functCode/op1/op2 inputs and captures result/remainder. It then writes back to the register file, adding the add/sub overflow and divide-by-zero detection the ALU lacks.

## Interface
Parameters:
- NREG, 16, register-file depth (fixed at 16; 4-bit register fields)
- W, 16, data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instr  in  16  instruction: [15:12] funct, [11:8] rd, [7:4] rs, [3:0] rt
- instr_valid  in  1  instruction present
- instr_ready  out  1  controller can accept (IDLE only)
- functCode  out  4  to ALU
- op1  out  16  to ALU, signed, = R[rs] latched
- op2  out  16  to ALU, signed, = R[rt] latched
- alu_result  in  16  from ALU result
- alu_remainder  in  16  from ALU remainder
- done  out  1  one-cycle pulse, instruction retired
- ovf  out  1  signed overflow of last retired add/sub
- dz  out  1  last retired div had op2 == 0
- illegal  out  1  last retired funct was undefined
- rem_q  out  16  remainder register (last successful div)
- dbg_addr  in  4  debug read address
- dbg_data  out  16  R[dbg_addr], combinational

## Operation
- Function codes: 0000 ADD, 0001 SUB, 0100 MUL, 0101 DIV, 0111 MOV, 1000 SWAP; all others illegal.
- R0 reads 0; writes to R0 discarded.
- States: IDLE, READ, EXEC, WB, WB2.
  - IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr → READ.
  - READ: op1_q<=R[rs], op2_q<=R[rt] → EXEC.
  - EXEC: functCode/op1/op2 driven from latches. At clock edge: res_q<=alu_result, rem_q candidate latched, flags computed → WB.
  - WB: perform write per funct. SWAP → WB2; others → IDLE with done=1 next cycle.
  - WB2 (SWAP only): R[rs]<=old R[rd] (captured at READ as third latch) → IDLE, done.
- Writeback rules:
  - ADD/SUB/MOV/MUL: R[rd]<=res_q. MUL keeps the low 16 bits. MOV ignores rt.
  - DIV: R[rd]<=quotient, rem_q<=remainder. If op2==0: no register write, rem_q unchanged, dz=1.
  - SWAP: WB writes R[rd]<=op1_q; WB2 writes R[rs]<=old R[rd].
  - Illegal: no writes, illegal=1.
- ovf: ADD sets it when op1,op2 have the same sign and result sign differs. SUB sets it when the signs differ and result sign ≠ op1 sign. 0 for all other functs.
- ovf/dz/illegal update only at retirement and hold until the next retirement.
- functCode/op1/op2 outputs hold their last values outside EXEC (no glitching to X).

## Timing
- Latency, handshake edge E0 → done high in cycle after E3 (4 cycles); SWAP 5 cycles. Throughput 1 instr / 4 cycles.
- instr_ready is registered-state decode: low from the cycle after acceptance until return to IDLE. The returning IDLE cycle may accept a new instruction (done and instr_ready both high that cycle).
- instr_valid while not ready is ignored; instr must be held by the producer until accepted.
- Register write visible to dbg_data and to a following READ on the next cycle. Back-to-back dependent instructions need no forwarding: the write completes before the next READ.
- Reset (async, any state): state→IDLE, register file and rem_q cleared to 0. functCode/op1/op2 = 0; done/ovf/dz/illegal = 0; instr_ready = 1 after reset deasserts. In-flight instruction aborted, no partial writeback (mid-SWAP leaves R[rd] possibly written; R[rs] not).

## Structure
- Package alu_pkg: funct-code localparams (FN_ADD…FN_SWAP), state enum, instruction field offsets.
- Sub-module alu_regfile: 16×16, two synchronous-latch read ports plus combinational debug port, one write port, R0 hardwired zero, async reset clear.
- ALU instantiated outside; this block connects only via functCode/op1/op2/alu_result/alu_remainder.

## Test plan
- R1=0x7FFF, R2=0x0001, ADD R3,R1,R2 → R3=0x8000, ovf=1, done exactly 4 cycles after accept.
- R1=0x0011 (17), R2=0x0005, DIV R4,R1,R2 → R4=3, rem_q=2, dz=0; then DIV R5,R1,R0 → R5 unchanged, rem_q still 2, dz=1.
- R1=0xFFFD (−3), R2=0x0004, MUL R6,R1,R2 → R6=0xFFF4, ovf=0; SUB R7,R0,R1 → R7=3.
- R1=0x1234, R2=0xABCD, SWAP rd=1, rs=2 → R1=0xABCD, R2=0x1234, done 5 cycles after accept; ADD with rd=0 → R0 still reads 0.
- Illegal funct 0010 → no register changes, illegal=1, done asserted; instr_valid held during busy → second instruction accepted only on the IDLE cycle.
- Assert rst during WB of ADD R3 → R3=0, all outputs 0, instr_ready=1 after release.
